skid_pipeline_chain: RTL

- Parametrised successor to the single-stage valid/ready pipeline register.
- Chains STAGES register slices between an upstream producer and a downstream consumer.
- Each slice is selectable at elaboration:
  - forward-only (registered data/valid, combinational ready), or
  - full skid buffer (registered data/valid and registered ready, which breaks the ready timing path).
- Sits on long datapath routes and module boundaries where both the forward and backward paths need registering. Full throughput in both modes.

---
 rtl/pipe_pkg.sv | 7 +
 rtl/skid_pipe_slice.sv | 46 ++++
 rtl/skid_pipeline_chain.sv | 55 +++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: slice mode selector and occupancy width helper shared by the pipeline chain
package pipe_pkg;
    typedef enum logic {SLICE_FWD, SLICE_SKID} slice_mode_t;
    function automatic int cnt_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction
endpackage

// File: rtl/skid_pipe_slice.sv
// skid_pipe_slice: one valid/ready register slice, forward-only or full skid buffer
module skid_pipe_slice import pipe_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter slice_mode_t SLICE_MODE = SLICE_SKID
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] up_data,
    input  logic                  up_valid,
    output logic                  up_ready,
    output logic [DATA_WIDTH-1:0] down_data,
    output logic                  down_valid,
    input  logic                  down_ready,
    output logic [1:0]            cnt
);
    logic [DATA_WIDTH-1:0] data_q, data_n, skid_d, skid_d_n;
    logic valid_q, valid_n, skid_v, skid_v_n, load;
    assign load = ~valid_q | down_ready;
    assign up_ready = (SLICE_MODE == SLICE_FWD) ? load : ~skid_v;
    assign down_data = data_q;
    assign down_valid = valid_q;
    assign cnt = {1'b0, valid_n} + {1'b0, skid_v_n};
    always_comb begin
        data_n = data_q;
        valid_n = valid_q;
        skid_d_n = skid_d;
        skid_v_n = skid_v;
        if (SLICE_MODE == SLICE_FWD) begin
            valid_n = load ? up_valid : valid_q;
            data_n = (load && up_valid) ? up_data : data_q;
        end else if (load) begin
            valid_n = skid_v | up_valid;
            data_n = skid_v ? skid_d : (up_valid ? up_data : data_q);
            skid_v_n = 1'b0;
        end else if (up_valid && !skid_v) begin
            skid_v_n = 1'b1;
            skid_d_n = up_data;
        end
    end
    always_ff @(posedge clk) begin
        data_q <= data_n;
        skid_d <= skid_d_n;
        valid_q <= reset ? 1'b0 : valid_n;
        skid_v <= reset ? 1'b0 : skid_v_n;
    end
endmodule

// File: rtl/skid_pipeline_chain.sv
// skid_pipeline_chain: STAGES chained valid/ready slices with a registered occupancy count
module skid_pipeline_chain import pipe_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int STAGES = 2,
    parameter slice_mode_t SLICE_MODE = SLICE_SKID,
    parameter int CNT_W = cnt_width(STAGES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      occupancy
);
    logic [DATA_WIDTH-1:0] d [STAGES+1];
    logic v [STAGES+1];
    logic r [STAGES+1];
    logic [1:0] c [STAGES];
    logic [CNT_W-1:0] occ_n;
    if (STAGES < 1) begin : g_bad
        $error("skid_pipeline_chain: STAGES must be >= 1");
    end
    assign d[0] = in_data;
    assign v[0] = in_valid;
    assign in_ready = r[0];
    assign out_data = d[STAGES];
    assign out_valid = v[STAGES];
    assign r[STAGES] = out_ready;
    for (genvar i = 0; i < STAGES; i++) begin : g_slice
        skid_pipe_slice #(
            .DATA_WIDTH(DATA_WIDTH),
            .SLICE_MODE(SLICE_MODE)
        ) u_slice (
            .clk(clk),
            .reset(reset),
            .up_data(d[i]),
            .up_valid(v[i]),
            .up_ready(r[i]),
            .down_data(d[i+1]),
            .down_valid(v[i+1]),
            .down_ready(r[i+1]),
            .cnt(c[i])
        );
    end
    always_comb begin
        occ_n = '0;
        for (int k = 0; k < STAGES; k++) occ_n = occ_n + CNT_W'(c[k]);
    end
    always_ff @(posedge clk) begin
        occupancy <= reset ? '0 : occ_n;
    end
endmodule
